char_sequencer: RTL and testbench
=================================

CHAR_SEQUENCER -- requirements
Module: char_sequencer

Interface
REQ-001 Parameter CLEAR_CHAR, default 8'h20, SHALL be the fill byte written to every cell during screen clear.
REQ-002 clk  input  1  single clock (pixel clock); all state SHALL change on its rising edge only.
REQ-003 clr  input  1  reset, synchronous and active-high.
REQ-004 in_data  input  8  ASCII command/character byte.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  block accepts a byte; a transfer SHALL occur on an edge where in_valid & in_ready.
REQ-007 cursor_x  input  6  current cursor column, 0..63.
REQ-008 cursor_y  input  4  current cursor row, 0..15.
REQ-009 new_cursor_x  output  6  cursor column to load.
REQ-010 new_cursor_y  output  4  cursor row to load.
REQ-011 write_cursor_pos  output  1  one-cycle load strobe for the cursor registers.
REQ-012 new_char  output  8  byte to write to the char buffer.
REQ-013 new_char_address  output  10  char buffer address, {row[3:0], col[5:0]}.
REQ-014 new_char_wen  output  1  char buffer write enable, one write per asserted cycle.
REQ-015 busy  output  1  high whenever state != IDLE.

Function
REQ-016 FSM states SHALL be IDLE, DECODE, CLEAR, SETTLE; all outputs SHALL be registered.
REQ-017 in_ready SHALL be 1 only in IDLE; on acceptance, in_data SHALL be latched and the state SHALL go to DECODE.
REQ-018 DECODE SHALL last one cycle and set outputs for the next cycle (state SETTLE, except FF) from the latched byte and the cursor_x/cursor_y sampled in DECODE.
REQ-019 0x20..0x7E: new_char_wen=1, new_char=byte, new_char_address={cursor_y,cursor_x}, write_cursor_pos=1, new_cursor_x = cursor_x==63 ? 63 : cursor_x+1, new_cursor_y=cursor_y.
REQ-020 0x08 (BS): write_cursor_pos=1, new_cursor_x = cursor_x==0 ? 0 : cursor_x-1, y unchanged, no write.
REQ-021 0x0D (CR): write_cursor_pos=1, new_cursor_x=0, y unchanged.
REQ-022 0x0A (LF): write_cursor_pos=1, new_cursor_y = cursor_y==15 ? 15 : cursor_y+1, x unchanged; no scrolling.
REQ-023 Any other byte except 0x0C: no strobes; state SHALL still pass through SETTLE.
REQ-024 0x0C (FF): state CLEAR, 10-bit counter from 0; each CLEAR cycle SHALL drive new_char_wen=1, new_char=CLEAR_CHAR, new_char_address=counter, counter+1.
REQ-025 The cycle writing address 1023 SHALL also assert write_cursor_pos with new_cursor_x=0, new_cursor_y=0; next state SETTLE; counter SHALL NOT wrap to a second pass.
REQ-026 In SETTLE all strobes SHALL be 0; next state IDLE, so the next command sees the updated cursor.
REQ-027 Strobes SHALL be high for exactly one cycle per command (1024 consecutive cycles for FF); when low, new_char_wen and write_cursor_pos SHALL be 0 and data outputs hold their last value.
REQ-028 Timing: byte accepted at edge E0 -> strobes high E1..E2 -> in_ready high after E2; throughput one non-FF byte per 3 cycles; FF occupies 1024 strobe cycles + SETTLE.
REQ-029 in_valid while not ready SHALL be ignored; in_data changes during busy SHALL not affect the executing command.

Reset
REQ-030 clr high at an edge SHALL force IDLE, counter=0, latched byte=0, new_cursor_x=0, new_cursor_y=0, new_char=0, new_char_address=0, all strobes=0, busy=0.
REQ-031 While clr is high, in_ready SHALL be 0 and no byte SHALL be accepted; clr SHALL dominate in_valid.
REQ-032 clr during CLEAR SHALL abort immediately; remaining cells are not written and the cursor is not reset.

Verification
REQ-033 cursor (5,3), send 'A' (0x41) -> one cycle wen=1, addr=0x0C5, char=0x41, write_cursor_pos=1, new=(6,3); in_ready low exactly 2 cycles.
REQ-034 cursor (63,15), send 'Z', then LF, then BS with cursor held (63,15) -> new=(63,15), (63,15), (62,15); no write on LF/BS.
REQ-035 cursor (0,0), send BS, CR, 0x07 -> new=(0,0), (0,0); 0x07 yields no strobe; busy 2 cycles each.
REQ-036 send FF -> exactly 1024 contiguous wen cycles, addresses 0..1023 ascending, char=0x20; last cycle write_cursor_pos=1, new=(0,0); then in_ready after 1 SETTLE cycle.
REQ-037 FF then clr at write 500 -> next cycle wen=0, busy=0, no write_cursor_pos; in_ready 1 after clr drops; subsequent 'A' works normally.
REQ-038 in_valid held high with changing in_data across 3 bytes -> exactly 3 commands, each using the byte present on its acceptance edge.

Source files
------------

// File: rtl/char_sequencer_if.sv
// Byte-command and character-buffer/cursor bundle for the character sequencer.
interface char_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] cursor_x;
  logic [3:0] cursor_y;
  logic [5:0] new_cursor_x;
  logic [3:0] new_cursor_y;
  logic       write_cursor_pos;
  logic [7:0] new_char;
  logic [9:0] new_char_address;
  logic       new_char_wen;
  logic       busy;

  // Command source / cursor owner side
  modport master (
    output in_data, in_valid, cursor_x, cursor_y,
    input  in_ready, new_cursor_x, new_cursor_y, write_cursor_pos,
           new_char, new_char_address, new_char_wen, busy
  );

  // Sequencer side
  modport slave (
    input  in_data, in_valid, cursor_x, cursor_y,
    output in_ready, new_cursor_x, new_cursor_y, write_cursor_pos,
           new_char, new_char_address, new_char_wen, busy
  );
endinterface

// File: rtl/char_sequencer.sv
// Turns ASCII command bytes into char-buffer writes and cursor loads.
// Printable bytes write at the cursor and advance it; BS/CR/LF move the
// cursor; FF fills the whole 64x16 screen with CLEAR_CHAR and homes the cursor.
module char_sequencer #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input logic             clk,
  input logic             clr,
  char_sequencer_if.slave bus
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned X_W     = 6;
  localparam int unsigned Y_W     = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;
  localparam logic [X_W-1:0]   X_MAX    = '1;
  localparam logic [Y_W-1:0]   Y_MAX    = '1;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LO = 8'h20;
  localparam logic [7:0] CH_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    CLEAR  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;

  logic             in_ready_d;
  logic             busy_d;
  logic [X_W-1:0]   ncx_d;
  logic [Y_W-1:0]   ncy_d;
  logic             wcp_d;
  logic [7:0]       char_d;
  logic [CNT_W-1:0] addr_d;
  logic             wen_d;

  assign accept_c = (state == IDLE) && bus.in_valid && bus.in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = DECODE;
      DECODE:  state_nxt = (cmd_q == CH_FF) ? CLEAR : SETTLE;
      CLEAR:   if (cnt_q == CNT_LAST) state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs, latched byte and clear counter
  always_comb begin
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    in_ready_d = (state_nxt == IDLE);
    busy_d     = (state_nxt != IDLE);
    ncx_d      = bus.new_cursor_x;
    ncy_d      = bus.new_cursor_y;
    char_d     = bus.new_char;
    addr_d     = bus.new_char_address;
    wcp_d      = 1'b0;
    wen_d      = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) cmd_d = bus.in_data;
      end
      DECODE: begin
        cnt_d = '0;
        if (cmd_q >= CH_LO && cmd_q <= CH_HI) begin
          wen_d  = 1'b1;
          char_d = cmd_q;
          addr_d = {bus.cursor_y, bus.cursor_x};
          wcp_d  = 1'b1;
          ncx_d  = (bus.cursor_x == X_MAX) ? X_MAX : bus.cursor_x + X_W'(1);
          ncy_d  = bus.cursor_y;
        end else begin
          case (cmd_q)
            CH_BS: begin
              wcp_d = 1'b1;
              ncx_d = (bus.cursor_x == '0) ? '0 : bus.cursor_x - X_W'(1);
              ncy_d = bus.cursor_y;
            end
            CH_CR: begin
              wcp_d = 1'b1;
              ncx_d = '0;
              ncy_d = bus.cursor_y;
            end
            CH_LF: begin
              wcp_d = 1'b1;
              ncx_d = bus.cursor_x;
              ncy_d = (bus.cursor_y == Y_MAX) ? Y_MAX : bus.cursor_y + Y_W'(1);
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        wen_d  = 1'b1;
        char_d = CLEAR_CHAR;
        addr_d = cnt_q;
        cnt_d  = cnt_q + CNT_W'(1);
        // Final cell also homes the cursor
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          wcp_d = 1'b1;
          ncx_d = '0;
          ncy_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Output, latched-byte and counter registers
  always_ff @(posedge clk) begin
    if (clr) begin
      cmd_q                <= '0;
      cnt_q                <= '0;
      bus.in_ready         <= 1'b0;
      bus.busy             <= 1'b0;
      bus.new_cursor_x     <= '0;
      bus.new_cursor_y     <= '0;
      bus.write_cursor_pos <= 1'b0;
      bus.new_char         <= '0;
      bus.new_char_address <= '0;
      bus.new_char_wen     <= 1'b0;
    end else begin
      cmd_q                <= cmd_d;
      cnt_q                <= cnt_d;
      bus.in_ready         <= in_ready_d;
      bus.busy             <= busy_d;
      bus.new_cursor_x     <= ncx_d;
      bus.new_cursor_y     <= ncy_d;
      bus.write_cursor_pos <= wcp_d;
      bus.new_char         <= char_d;
      bus.new_char_address <= addr_d;
      bus.new_char_wen     <= wen_d;
    end
  end

endmodule

// File: tb/tb_char_sequencer.sv
// Directed bench for char_sequencer with hand-computed expectations.
module tb_char_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  // Values the data outputs must hold when their strobe is low
  logic [7:0] last_char = 8'h00;
  logic [9:0] last_addr = 10'h000;
  logic [5:0] last_x    = 6'd0;
  logic [3:0] last_y    = 4'd0;

  char_sequencer_if bus ();

  char_sequencer #(.CLEAR_CHAR(8'h20)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 50 && bus.in_ready !== 1'b1; i++) tick();
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // One non-FF command: accept, strobe cycle, settle cycle
  task automatic run_cmd(input string tag, input logic [7:0] b,
                         input logic [5:0] cx, input logic [3:0] cy,
                         input logic exp_wen, input logic [9:0] exp_addr,
                         input logic exp_wcp, input logic [5:0] exp_x, input logic [3:0] exp_y);
    bus.cursor_x = cx;
    bus.cursor_y = cy;
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h0C;
    check({tag, "_rdy_e0"},  32'(bus.in_ready), 32'd0);
    check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    check({tag, "_wen_e0"},  32'(bus.new_char_wen), 32'd0);
    tick();
    check({tag, "_rdy_e1"},  32'(bus.in_ready), 32'd0);
    check({tag, "_busy_e1"}, 32'(bus.busy), 32'd1);
    check({tag, "_wen"},     32'(bus.new_char_wen), 32'(exp_wen));
    check({tag, "_wcp"},     32'(bus.write_cursor_pos), 32'(exp_wcp));
    if (exp_wen) begin
      last_char = b;
      last_addr = exp_addr;
    end
    if (exp_wcp) begin
      last_x = exp_x;
      last_y = exp_y;
    end
    check({tag, "_char"}, 32'(bus.new_char), 32'(last_char));
    check({tag, "_addr"}, 32'(bus.new_char_address), 32'(last_addr));
    check({tag, "_ncx"},  32'(bus.new_cursor_x), 32'(last_x));
    check({tag, "_ncy"},  32'(bus.new_cursor_y), 32'(last_y));
    tick();
    check({tag, "_wen_e2"},  32'(bus.new_char_wen), 32'd0);
    check({tag, "_wcp_e2"},  32'(bus.write_cursor_pos), 32'd0);
    check({tag, "_busy_e2"}, 32'(bus.busy), 32'd0);
    check({tag, "_rdy_e2"},  32'(bus.in_ready), 32'd1);
    check({tag, "_hold_e2"}, 32'(bus.new_char), 32'(last_char));
  endtask

  task automatic start_ff(input string tag);
    bus.cursor_x = 6'd17;
    bus.cursor_y = 4'd9;
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0C;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h41;
  endtask

  initial begin
    int n_wen, bad, gaps, wcp_n, wcp_addr, exp_addr, rdy_after, found;
    logic [5:0] wx;
    logic [3:0] wy;
    logic prev_wen;
    logic [7:0] got_ch [$];

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.cursor_x = 6'd0;
    bus.cursor_y = 4'd0;

    // Reset, with a byte offered that must be ignored
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    tick();
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_wen",   32'(bus.new_char_wen), 32'd0);
    check("rst_wcp",   32'(bus.write_cursor_pos), 32'd0);
    check("rst_char",  32'(bus.new_char), 32'd0);
    check("rst_addr",  32'(bus.new_char_address), 32'd0);
    check("rst_ncx",   32'(bus.new_cursor_x), 32'd0);
    check("rst_ncy",   32'(bus.new_cursor_y), 32'd0);
    bus.in_valid = 1'b0;
    clr = 1'b0;
    tick();
    check("rst_rel_ready", 32'(bus.in_ready), 32'd1);

    // Printable / cursor commands
    run_cmd("A_5_3",    8'h41, 6'd5,  4'd3,  1'b1, 10'h0C5, 1'b1, 6'd6,  4'd3);
    run_cmd("Z_63_15",  8'h5A, 6'd63, 4'd15, 1'b1, 10'h3FF, 1'b1, 6'd63, 4'd15);
    run_cmd("LF_63_15", 8'h0A, 6'd63, 4'd15, 1'b0, 10'h000, 1'b1, 6'd63, 4'd15);
    run_cmd("BS_63_15", 8'h08, 6'd63, 4'd15, 1'b0, 10'h000, 1'b1, 6'd62, 4'd15);
    run_cmd("BS_0_0",   8'h08, 6'd0,  4'd0,  1'b0, 10'h000, 1'b1, 6'd0,  4'd0);
    run_cmd("CR_0_0",   8'h0D, 6'd0,  4'd0,  1'b0, 10'h000, 1'b1, 6'd0,  4'd0);
    run_cmd("BEL",      8'h07, 6'd0,  4'd0,  1'b0, 10'h000, 1'b0, 6'd0,  4'd0);
    run_cmd("CR_20_7",  8'h0D, 6'd20, 4'd7,  1'b0, 10'h000, 1'b1, 6'd0,  4'd7);
    run_cmd("LF_4_2",   8'h0A, 6'd4,  4'd2,  1'b0, 10'h000, 1'b1, 6'd4,  4'd3);
    run_cmd("BS_10_1",  8'h08, 6'd10, 4'd1,  1'b0, 10'h000, 1'b1, 6'd9,  4'd1);
    run_cmd("TILDE",    8'h7E, 6'd62, 4'd0,  1'b1, 10'h03E, 1'b1, 6'd63, 4'd0);
    run_cmd("SPACE",    8'h20, 6'd1,  4'd8,  1'b1, 10'h201, 1'b1, 6'd2,  4'd8);
    run_cmd("DEL",      8'h7F, 6'd1,  4'd8,  1'b0, 10'h000, 1'b0, 6'd0,  4'd0);
    run_cmd("US",       8'h1F, 6'd1,  4'd8,  1'b0, 10'h000, 1'b0, 6'd0,  4'd0);

    // Full screen clear
    start_ff("ff");
    n_wen = 0; bad = 0; gaps = 0; wcp_n = 0; wcp_addr = -1; exp_addr = 0;
    rdy_after = 0; prev_wen = 1'b0; wx = 6'h3F; wy = 4'hF;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (bus.new_char_wen) begin
        if (32'(bus.new_char_address) != exp_addr || bus.new_char != 8'h20) bad++;
        if (n_wen > 0 && !prev_wen) gaps++;
        if (bus.write_cursor_pos) begin
          wcp_n++;
          wcp_addr = 32'(bus.new_char_address);
          wx = bus.new_cursor_x;
          wy = bus.new_cursor_y;
        end
        exp_addr++;
        n_wen++;
      end else if (bus.write_cursor_pos) begin
        wcp_n++;
      end
      if (prev_wen && !bus.new_char_wen) rdy_after = 32'(bus.in_ready);
      prev_wen = bus.new_char_wen;
      if (bus.in_ready) break;
    end
    check("ff_wen_count", 32'(n_wen), 32'd1024);
    check("ff_addr_char", 32'(bad), 32'd0);
    check("ff_contiguous", 32'(gaps), 32'd0);
    check("ff_wcp_count", 32'(wcp_n), 32'd1);
    check("ff_wcp_addr", 32'(wcp_addr), 32'd1023);
    check("ff_home_x", 32'(wx), 32'd0);
    check("ff_home_y", 32'(wy), 32'd0);
    check("ff_ready_after", 32'(rdy_after), 32'd1);
    check("ff_busy_end", 32'(bus.busy), 32'd0);
    last_char = 8'h20; last_addr = 10'h3FF; last_x = 6'd0; last_y = 4'd0;
    run_cmd("post_ff_B", 8'h42, 6'd0, 4'd0, 1'b1, 10'h000, 1'b1, 6'd1, 4'd0);

    // Clear aborted by reset at the 500th cell
    start_ff("abort");
    found = 0;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (bus.new_char_wen && bus.new_char_address == 10'd500) begin
        found = 1;
        break;
      end
    end
    check("abort_reach500", 32'(found), 32'd1);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    tick();
    check("abort_wen",   32'(bus.new_char_wen), 32'd0);
    check("abort_busy",  32'(bus.busy), 32'd0);
    check("abort_wcp",   32'(bus.write_cursor_pos), 32'd0);
    check("abort_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("abort_ready2", 32'(bus.in_ready), 32'd0);
    check("abort_wen2",   32'(bus.new_char_wen), 32'd0);
    clr = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("abort_rel_ready", 32'(bus.in_ready), 32'd1);
    check("abort_rel_wen",   32'(bus.new_char_wen), 32'd0);
    check("abort_rel_busy",  32'(bus.busy), 32'd0);
    last_char = 8'h00; last_addr = 10'h000; last_x = 6'd0; last_y = 4'd0;
    run_cmd("post_abort_A", 8'h41, 6'd5, 4'd3, 1'b1, 10'h0C5, 1'b1, 6'd6, 4'd3);

    // in_valid held high with a new byte every cycle: accepts on edges 0, 3, 6
    bus.cursor_x = 6'd0;
    bus.cursor_y = 4'd5;
    wait_ready("stream");
    for (int i = 0; i < 12; i++) begin
      if (i < 9) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h30 + 8'(i);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (bus.new_char_wen) got_ch.push_back(bus.new_char);
    end
    check("stream_count", 32'(got_ch.size()), 32'd3);
    while (got_ch.size() < 3) got_ch.push_back(8'h00);
    check("stream_b0", 32'(got_ch[0]), 32'h30);
    check("stream_b1", 32'(got_ch[1]), 32'h33);
    check("stream_b2", 32'(got_ch[2]), 32'h36);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
